// File: rtl/skein512_pkg.sv
// Skein-512 constants, types and Threefish helper functions shared by the
// iterative core and its 4-round mixing stage.
package skein512_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned NWORDS = 8;
    localparam int unsigned GROUPS = 18;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [NWORDS-1:0] block_t;
    typedef word_t [NWORDS:0]   key_t;
    typedef word_t [2:0]        tweak_t;

    typedef enum logic [1:0] {IDLE, MSG, OUT, DONE} state_t;

    localparam word_t C240   = 64'h1BD1_1BDA_A9FC_1A22;
    localparam word_t T0_MSG = 64'h0000_0000_0000_0050;
    localparam word_t T1_MSG = 64'hB000_0000_0000_0000;
    localparam word_t T0_OUT = 64'h0000_0000_0000_0008;
    localparam word_t T1_OUT = 64'hFF00_0000_0000_0000;

    localparam int unsigned R [8][4] = '{
        '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44,  9, 54, 56},
        '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{ 8, 35, 56, 22}
    };

    function automatic word_t rotl(word_t x, int unsigned r);
        return (x << r) | (x >> (WORD_W - r));
    endfunction

    // Nine-word key schedule: the eight key words plus the parity word.
    function automatic key_t expand_key(block_t k);
        key_t e;
        e[NWORDS] = C240;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            e[i]      = k[i];
            e[NWORDS] = e[NWORDS] ^ k[i];
        end
        return e;
    endfunction

    function automatic tweak_t expand_tweak(word_t t0, word_t t1);
        return {t0 ^ t1, t1, t0};
    endfunction

    function automatic block_t subkey(key_t k, tweak_t t, logic [4:0] s);
        block_t sk;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            sk[i] = k[4'((32'(s) + i) % 9)];
        end
        sk[5] = sk[5] + t[2'(32'(s) % 3)];
        sk[6] = sk[6] + t[2'((32'(s) + 1) % 3)];
        sk[7] = sk[7] + WORD_W'(s);
        return sk;
    endfunction

    function automatic block_t add_block(block_t a, block_t b);
        block_t r;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            r[i] = a[i] + b[i];
        end
        return r;
    endfunction

    // One Threefish-512 round: four MIX operations then the word permutation.
    function automatic block_t mix_round(block_t x, logic [2:0] d);
        block_t f;
        for (int unsigned j = 0; j < 4; j++) begin
            f[2*j]   = x[2*j] + x[2*j+1];
            f[2*j+1] = rotl(x[2*j+1], R[d][2'(j)]) ^ f[2*j];
        end
        return {f[3], f[0], f[5], f[6], f[7], f[4], f[1], f[2]};
    endfunction

    function automatic block_t make_pt(logic [95:0] d, logic [31:0] n);
        block_t p;
        p    = '0;
        p[0] = d[63:0];
        p[1] = {n[7:0], n[15:8], n[23:16], n[31:24], d[95:64]};
        return p;
    endfunction

    function automatic logic [511:0] bswap512(block_t x);
        logic [511:0] v;
        logic [511:0] r;
        v = x;
        for (int unsigned i = 0; i < 64; i++) begin
            r[8*i +: 8] = v[8*(63-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/skein512_mix4.sv
// Combinational Threefish-512 group: subkey s injection followed by four rounds.
module skein512_mix4
    import skein512_pkg::*;
(
    input  logic [511:0] state,
    input  logic [575:0] key,
    input  logic [191:0] tweak,
    input  logic [4:0]   s,
    output logic [511:0] result
);

    block_t v;

    // Rounds 4s..4s+3 use rotation rows 0-3 for even s, rows 4-7 for odd s.
    always_comb begin
        v = add_block(state, subkey(key, tweak, s));
        for (int unsigned r = 0; r < 4; r++) begin
            v = mix_round(v, {s[0], 2'(r)});
        end
        result = v;
    end

endmodule

// File: rtl/skein512_iter.sv
// Iterative Skein-512 core: message block then output block, UNROLL groups per cycle.
// Define SKEIN512_HIT_EN to add the target register and the hash <= target comparator.
module skein512_iter
    import skein512_pkg::*;
#(
    parameter int unsigned UNROLL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] midstate,
    input  logic [95:0]  data,
    input  logic [31:0]  nonce,
    input  logic [63:0]  target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] hash,
    output logic [31:0]  out_nonce,
    output logic         hit
);

    localparam int unsigned LAST_S = GROUPS - UNROLL;

    state_t       state;
    state_t       state_next;
    block_t       key_q;
    block_t       v_q;
    logic [95:0]  data_q;
    logic [31:0]  nonce_q;
    logic [4:0]   s_q;
    key_t         key_x;
    tweak_t       tweak_c;
    block_t       chain [UNROLL+1];
    block_t       final_c;
    block_t       pt_c;
    logic [511:0] hash_c;
    logic         last;
    logic         accept;

    assign accept  = in_valid && in_ready;
    assign key_x   = expand_key(key_q);
    assign tweak_c = (state == OUT) ? expand_tweak(T0_OUT, T1_OUT)
                                    : expand_tweak(T0_MSG, T1_MSG);
    assign chain[0] = v_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_mix
        skein512_mix4 u_mix4 (
            .state  (chain[g]),
            .key    (key_x),
            .tweak  (tweak_c),
            .s      (s_q + 5'(g)),
            .result (chain[g+1])
        );
    end

    // Block finish: final subkey add; plaintext feed-forward applied only after MSG.
    assign final_c = add_block(chain[UNROLL], subkey(key_x, tweak_c, 5'(GROUPS)));
    assign pt_c    = make_pt(data_q, nonce_q);
    assign hash_c  = bswap512(final_c);
    assign last    = (s_q == 5'(LAST_S));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = MSG;
            MSG:     if (last)      state_next = OUT;
            OUT:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            v_q       <= '0;
            data_q    <= '0;
            nonce_q   <= '0;
            s_q       <= '0;
            hash      <= '0;
            out_nonce <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_q   <= midstate;
                        v_q     <= make_pt(data, nonce);
                        data_q  <= data;
                        nonce_q <= nonce;
                        s_q     <= '0;
                    end
                end
                MSG, OUT: begin
                    if (!last) begin
                        v_q <= chain[UNROLL];
                        s_q <= s_q + 5'(UNROLL);
                    end else begin
                        v_q <= '0;
                        s_q <= '0;
                        if (state == MSG) begin
                            key_q <= final_c ^ pt_c;
                        end else begin
                            hash      <= hash_c;
                            out_nonce <= nonce_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SKEIN512_HIT_EN
    logic [63:0] target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            hit      <= 1'b0;
        end else begin
            if (accept) begin
                target_q <= target;
            end
            if (state == OUT && last) begin
                hit <= (hash_c[511:448] <= target_q);
            end
        end
    end
`else
    logic unused_target;
    assign unused_target = ^target;
    assign hit           = 1'b0;
`endif

endmodule

// File: tb/tb_skein512_iter.sv
// Randomized self-checking bench for skein512_iter against a plain Threefish/Skein model.
module tb_skein512_iter;

    localparam int UNROLL = 2;
    localparam int STEPS  = 18 / UNROLL;
    localparam int LAT    = 2 * STEPS + 1;
    localparam int PERIOD = 10;

    localparam int ROTS [8][4] = '{
        '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44,  9, 54, 56},
        '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{ 8, 35, 56, 22}
    };
    localparam int PERM [8] = '{2, 1, 4, 7, 6, 5, 0, 3};

    typedef logic [7:0][63:0] blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] midstate;
    logic [95:0]  data;
    logic [31:0]  nonce;
    logic [63:0]  target;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] hash;
    logic [31:0]  out_nonce;
    logic         hit;

    int  n_checks = 0;
    int  n_pass   = 0;
    time accept_time;

    skein512_iter #(.UNROLL(UNROLL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .midstate  (midstate),
        .data      (data),
        .nonce     (nonce),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hash      (hash),
        .out_nonce (out_nonce),
        .hit       (hit)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rotl64(logic [63:0] x, int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic blk_t inject(blk_t v, logic [8:0][63:0] ks, logic [2:0][63:0] ts, int s);
        for (int i = 0; i < 8; i++) v[i] = v[i] + ks[(s + i) % 9];
        v[5] = v[5] + ts[s % 3];
        v[6] = v[6] + ts[(s + 1) % 3];
        v[7] = v[7] + 64'(s);
        return v;
    endfunction

    // Full 72-round Threefish-512 block with feed-forward of the plaintext.
    function automatic blk_t threefish(blk_t key, logic [63:0] tw0, logic [63:0] tw1, blk_t pt);
        logic [8:0][63:0] ks;
        logic [2:0][63:0] ts;
        blk_t v;
        blk_t f;
        ks[8] = 64'h1BD11BDAA9FC1A22;
        for (int i = 0; i < 8; i++) begin
            ks[i] = key[i];
            ks[8] = ks[8] ^ key[i];
        end
        ts[0] = tw0;
        ts[1] = tw1;
        ts[2] = tw0 ^ tw1;
        v = pt;
        for (int d = 0; d < 72; d++) begin
            if (d % 4 == 0) v = inject(v, ks, ts, d / 4);
            for (int j = 0; j < 4; j++) begin
                f[2*j]   = v[2*j] + v[2*j+1];
                f[2*j+1] = rotl64(v[2*j+1], ROTS[d % 8][j]) ^ f[2*j];
            end
            for (int i = 0; i < 8; i++) v[i] = f[PERM[i]];
        end
        v = inject(v, ks, ts, 18);
        return v ^ pt;
    endfunction

    function automatic logic [511:0] model_hash(logic [511:0] m, logic [95:0] d, logic [31:0] n);
        blk_t pt;
        blk_t k2;
        blk_t o;
        logic [511:0] ov;
        logic [511:0] h;
        pt    = '0;
        pt[0] = d[63:0];
        pt[1] = {n[7:0], n[15:8], n[23:16], n[31:24], d[95:64]};
        k2 = threefish(m, 64'h50, 64'hB000000000000000, pt);
        o  = threefish(k2, 64'h8, 64'hFF00000000000000, '0);
        ov = o;
        for (int i = 0; i < 64; i++) h[8*i +: 8] = ov[8*(63-i) +: 8];
        return h;
    endfunction

    function automatic logic hit_model(logic [511:0] h, logic [63:0] t);
`ifdef SKEIN512_HIT_EN
        return h[511:448] <= t;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge where the result is seen
    // (hold=0) or just after the delayed transfer (hold>0).
    task automatic run_job(input logic [511:0] m, input logic [95:0] d, input logic [31:0] n,
                           input logic [63:0] t, input int hold);
        logic [511:0] eh;
        logic         ehit;
        int           lat;
        int           guard;
        eh   = model_hash(m, d, n);
        ehit = hit_model(eh, t);
        midstate = m;
        data     = d;
        nonce    = n;
        target   = t;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        accept_time = $time;
        @(negedge clk);
        in_valid = 1'b0;
        midstate = rand512();
        data     = {$urandom, $urandom, $urandom};
        nonce    = $urandom;
        target   = {$urandom, $urandom};
        check("busy_in_ready", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
        if (hold > 0) out_ready = 1'b0;
        check("hash", hash, eh);
        check("out_nonce", out_nonce, n);
        check("hit", hit, ehit);
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check("hold_hash", hash, eh);
                check("hold_nonce", out_nonce, n);
                check("hold_hit", hit, ehit);
                check("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("xfer_out_valid", out_valid, 0);
            check("xfer_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        logic [511:0] m;
        logic [95:0]  d;
        logic [31:0]  n;
        logic [511:0] h;
        time          t_rel;
        time          t_first;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        midstate  = '0;
        data      = '0;
        nonce     = '0;
        target    = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_hash", hash, 0);
        check("rst_out_nonce", out_nonce, 0);
        check("rst_hit", hit, 0);

        // All-zero job, accepted on the first edge after reset release
        rst_n = 1'b1;
        t_rel = $time;
        run_job('0, '0, '0, {$urandom, $urandom}, 0);
        check("rst_to_accept", 512'(accept_time - t_rel), PERIOD / 2);

        // Hit threshold boundaries on one random job
        m = rand512();
        d = {$urandom, $urandom, $urandom};
        n = $urandom;
        h = model_hash(m, d, n);
        run_job(m, d, n, h[511:448], 0);
        run_job(m, d, n, h[511:448] - 64'd1, 0);
        run_job(m, d, n, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Backpressure: result held for 10 cycles
        run_job(rand512(), {$urandom, $urandom, $urandom}, $urandom, {$urandom, $urandom}, 10);

        // Back-to-back nonce extremes with out_ready held high
        m = rand512();
        d = {$urandom, $urandom, $urandom};
        run_job(m, d, 32'hFFFF_FFFF, {$urandom, $urandom}, 0);
        t_first = accept_time;
        run_job(m, d, 32'h0000_0000, {$urandom, $urandom}, 0);
        check("b2b_spacing", 512'(accept_time - t_first), (2 * STEPS + 2) * PERIOD);

        // Reset pulsed while the message block is in flight
        @(negedge clk);
        midstate = rand512();
        data     = {$urandom, $urandom, $urandom};
        nonce    = $urandom;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_hash", hash, 0);
        check("midrst_out_nonce", out_nonce, 0);
        check("midrst_hit", hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = $time;
        run_job(rand512(), {$urandom, $urandom, $urandom}, $urandom, {$urandom, $urandom}, 0);
        check("midrst_to_accept", 512'(accept_time - t_rel), PERIOD / 2);

        // Random jobs with short random backpressure
        for (int k = 0; k < 6; k++) begin
            run_job(rand512(), {$urandom, $urandom, $urandom}, $urandom,
                    {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
